// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Sub-word lane handling: load extract/extend and store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (offset)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    unique case (1'b1)
      funct3 == F3_B:  load_data = {{24{b[7]}}, b};
      funct3 == F3_H:  load_data = {{16{h[15]}}, h};
      funct3 == F3_W:  load_data = rdata;
      funct3 == F3_BU: load_data = {24'd0, b};
      funct3 == F3_HU: load_data = {16'd0, h};
      default:         load_data = '0;
    endcase
  end

  // Halfword lanes follow offset[1] only, so odd offsets align down.
  always_comb begin
    merged = rdata;
    unique case (1'b1)
      funct3 == F3_B: begin
        unique case (offset)
          2'd0: merged[7:0]   = sdata[7:0];
          2'd1: merged[15:8]  = sdata[7:0];
          2'd2: merged[23:16] = sdata[7:0];
          2'd3: merged[31:24] = sdata[7:0];
        endcase
      end
      funct3 == F3_H: begin
        if (offset[1]) merged[31:16] = sdata[15:0];
        else           merged[15:0]  = sdata[15:0];
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: sub-word loads, single-cycle SW, two-cycle RMW for SB/SH.
// Optional LSU_MISALIGN_TRAP_EN suppresses and flags misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 6
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_StoreData,
  output logic [31:0] o_LoadData,
  output logic        o_Stall,
  output logic        o_Misaligned,
  output logic        o_MemWEnable,
  output logic [31:0] o_MemAddr,
  output logic [31:0] o_MemWData,
  input  logic [31:0] i_MemRData
);

  localparam int AW = ADDR_WORDS_LOG2;

  lsu_state_t    state;
  logic [AW-1:0] r_Idx;
  logic [AW-1:0] idx;
  logic [31:0]   r_Merged;
  logic [31:0]   ld;
  logic [31:0]   merged;
  logic          trap;
  logic          st_ok;
  logic          sw_go;
  logic          sub_go;
  logic          unused_addr;

  assign idx = i_Addr[AW+1:2];
  assign unused_addr = ^i_Addr[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic half;
  logic word;
  logic mis;
  assign half = (i_Funct3 == F3_H) | (i_Funct3 == F3_HU);
  assign word = (i_Funct3 == F3_W);
  assign mis  = (half & i_Addr[0]) | (word & |i_Addr[1:0]);
  assign trap = mis;
  assign o_Misaligned = i_Reset & i_Valid
                      & (i_MemRead | i_MemWrite) & mis;
`else
  assign trap = 1'b0;
  assign o_Misaligned = 1'b0;
`endif

  lsu_lane_align u_align (
    .funct3    (i_Funct3),
    .offset    (i_Addr[1:0]),
    .rdata     (i_MemRData),
    .sdata     (i_StoreData),
    .load_data (ld),
    .merged    (merged)
  );

  assign st_ok  = (state == IDLE) & i_Valid & i_MemWrite & ~trap;
  assign sw_go  = st_ok & (i_Funct3 == F3_W);
  assign sub_go = st_ok & ((i_Funct3 == F3_B) | (i_Funct3 == F3_H));

  assign o_LoadData = (i_Reset & i_Valid & i_MemRead & ~trap)
                    ? ld : 32'd0;
  assign o_Stall = i_Reset & sub_go;
  assign o_MemWEnable = i_Reset & ((state == RMW_WR) | sw_go);
  assign o_MemAddr = {{(32-AW){1'b0}},
                      (state == RMW_WR) ? r_Idx : idx};

  always_comb begin
    o_MemWData = 32'd0;
    if (i_Reset) begin
      if (state == RMW_WR) o_MemWData = r_Merged;
      else if (sw_go)      o_MemWData = i_StoreData;
    end
  end

  // RMW_WR always returns to IDLE so a held store cannot re-trigger.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state    <= IDLE;
      r_Idx    <= '0;
      r_Merged <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sub_go) begin
            r_Idx    <= idx;
            r_Merged <= merged;
            state    <= RMW_WR;
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-array memory, spec model, per-cycle compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] sdata = 32'd0;
  logic [31:0] ld_o;
  logic        stall_o;
  logic        mis_o;
  logic        wen_o;
  logic [31:0] maddr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata;

  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;

  bit          m_pend = 1'b0;
  logic [5:0]  m_idx = 6'd0;
  logic [31:0] m_data = 32'd0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Valid      (valid),
    .i_MemRead    (rd),
    .i_MemWrite   (wr),
    .i_Funct3     (f3),
    .i_Addr       (addr),
    .i_StoreData  (sdata),
    .o_LoadData   (ld_o),
    .o_Stall      (stall_o),
    .o_Misaligned (mis_o),
    .o_MemWEnable (wen_o),
    .o_MemAddr    (maddr_o),
    .o_MemWData   (wdata_o),
    .i_MemRData   (rdata)
  );

  assign rdata = mem[maddr_o[5:0]];

  always @(posedge clk)
    if (wen_o) mem[maddr_o[5:0]] <= wdata_o;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Spec-level model: outputs from access size, offset and one pending write.
  function automatic void model(
    output logic [31:0] e_ld, output logic e_stall,
    output logic e_wen, output logic e_mis,
    output logic [31:0] e_addr, output logic [31:0] e_wdata,
    output logic [31:0] e_merge);
    int size;
    bit sgn;
    bit bad;
    bit trap;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] v;
    size = 0;
    sgn  = 1'b0;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: size = 4;
      3'b100: size = 1;
      3'b101: size = 2;
      default: size = 0;
    endcase
    off  = addr[1:0];
    bad  = (size == 2 && off[0]) || (size == 4 && off != 2'd0);
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = bad;
`endif
    if (size == 2) off = {off[1], 1'b0};
    if (size == 4) off = 2'd0;
    word = mem[addr[7:2]];
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    v = (word >> (8 * off)) & mask;
    if (sgn && size < 4 && ((v >> (8 * size - 1)) & 32'd1) != 0)
      v = v | ~mask;
    e_merge = (word & ~(mask << (8 * off)))
            | ((sdata << (8 * off)) & (mask << (8 * off)));
    e_addr  = m_pend ? {26'd0, m_idx} : {26'd0, addr[7:2]};
    e_ld = 32'd0;
    e_stall = 1'b0;
    e_wen = 1'b0;
    e_mis = 1'b0;
    e_wdata = 32'd0;
    if (rst) begin
      e_mis = trap && valid && (rd || wr);
      if (valid && rd && size != 0 && !trap) e_ld = v;
      if (m_pend) begin
        e_wen = 1'b1;
        e_wdata = m_data;
      end else if (valid && wr && !trap && f3 <= 3'b010) begin
        if (size == 4) begin
          e_wen = 1'b1;
          e_wdata = sdata;
        end else begin
          e_stall = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [31:0] l, a, w, mg;
    logic s, we, ms;
    if (!rst) begin
      m_pend <= 1'b0;
    end else begin
      model(l, s, we, ms, a, w, mg);
      if (m_pend) m_pend <= 1'b0;
      else if (s) begin
        m_pend <= 1'b1;
        m_idx  <= addr[7:2];
        m_data <= mg;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] l, a, w, mg;
    logic s, we, ms;
    model(l, s, we, ms, a, w, mg);
    chk("cyc_load", ld_o, l);
    chk("cyc_stall", {31'd0, stall_o}, {31'd0, s});
    chk("cyc_wen", {31'd0, wen_o}, {31'd0, we});
    chk("cyc_mis", {31'd0, mis_o}, {31'd0, ms});
    chk("cyc_addr", maddr_o, a);
    chk("cyc_wdata", wdata_o, w);
  end

  task automatic drv(bit v, bit r, bit w, logic [2:0] f,
                     logic [31:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    valid = v; rd = r; wr = w; f3 = f; addr = a; sdata = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h8001_7FFF;
    mem[3] = 32'h1122_3344;
    mem[5] = 32'h8899_AABB;
    mem[6] = 32'h0102_0304;
    valid = 1'b1; rd = 1'b1; f3 = 3'b010; addr = 32'h14;
    #2;
    chk("reset_load", ld_o, 32'd0);
    chk("reset_wen", {31'd0, wen_o}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_wdata", wdata_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    drv(1, 1, 0, 3'b000, 32'h17, 0); @(negedge clk);
    chk("lb_17", ld_o, 32'hFFFF_FF88);
    drv(1, 1, 0, 3'b100, 32'h14, 0); @(negedge clk);
    chk("lbu_14", ld_o, 32'h0000_00BB);
    drv(1, 1, 0, 3'b001, 32'h16, 0); @(negedge clk);
    chk("lh_16", ld_o, 32'hFFFF_8899);
    drv(1, 1, 0, 3'b101, 32'h14, 0); @(negedge clk);
    chk("lhu_14", ld_o, 32'h0000_AABB);
    drv(1, 1, 0, 3'b110, 32'h14, 0); @(negedge clk);
    chk("ld_badf3", ld_o, 32'd0);

    drv(1, 0, 1, 3'b010, 32'h08, 32'hDEAD_BEEF); @(negedge clk);
    chk("sw_wen", {31'd0, wen_o}, 32'd1);
    chk("sw_addr", maddr_o, 32'd2);
    chk("sw_stall", {31'd0, stall_o}, 32'd0);
    drv(1, 1, 0, 3'b010, 32'h08, 0); @(negedge clk);
    chk("lw_08", ld_o, 32'hDEAD_BEEF);

    drv(1, 0, 1, 3'b000, 32'h0D, 32'h55); @(negedge clk);
    chk("sb_c1_stall", {31'd0, stall_o}, 32'd1);
    chk("sb_c1_wen", {31'd0, wen_o}, 32'd0);
    @(negedge clk);
    chk("sb_c2_wen", {31'd0, wen_o}, 32'd1);
    chk("sb_c2_addr", maddr_o, 32'd3);
    chk("sb_c2_wdata", wdata_o, 32'h1122_5544);
    chk("sb_c2_stall", {31'd0, stall_o}, 32'd0);
    drv(0, 0, 0, 3'b000, 32'h0, 0); @(negedge clk);
    chk("sb_c3_wen", {31'd0, wen_o}, 32'd0);
    chk("sb_mem3", mem[3], 32'h1122_5544);

    drv(1, 0, 1, 3'b001, 32'h12, 32'h0000_CAFE); @(negedge clk);
    @(negedge clk);
    drv(0, 0, 0, 3'b000, 32'h0, 0); @(negedge clk);
    chk("sh_mem4", mem[4], 32'hCAFE_0000);
    drv(1, 0, 1, 3'b001, 32'h112, 32'h0000_BEEF); @(negedge clk);
    chk("sh_wrap_addr", maddr_o, 32'd4);
    @(negedge clk);
    drv(0, 0, 0, 3'b000, 32'h0, 0); @(negedge clk);
    chk("sh_wrap_mem4", mem[4], 32'hBEEF_0000);

    drv(1, 0, 1, 3'b011, 32'h10, 32'h1234_5678); @(negedge clk);
    chk("st_badf3_wen", {31'd0, wen_o}, 32'd0);
    chk("st_badf3_stall", {31'd0, stall_o}, 32'd0);

    drv(1, 0, 1, 3'b000, 32'h18, 32'hAA); @(negedge clk);
    chk("rst_rmw_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_rmw_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_rmw_wdata", wdata_o, 32'd0);
    #1 valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_rmw_idle_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_rmw_mem6", mem[6], 32'h0102_0304);

    drv(1, 0, 1, 3'b010, 32'h0A, 32'h1234_5678); @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_sw_flag", {31'd0, mis_o}, 32'd1);
    chk("mis_sw_wen", {31'd0, wen_o}, 32'd0);
`else
    chk("mis_sw_flag", {31'd0, mis_o}, 32'd0);
    chk("mis_sw_wen", {31'd0, wen_o}, 32'd1);
    chk("mis_sw_addr", maddr_o, 32'd2);
`endif
    drv(1, 1, 0, 3'b001, 32'h03, 0); @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lh_flag", {31'd0, mis_o}, 32'd1);
    chk("mis_lh_load", ld_o, 32'd0);
    chk("mis_mem2", mem[2], 32'hDEAD_BEEF);
`else
    chk("mis_lh_load", ld_o, 32'hFFFF_8001);
    chk("mis_mem2", mem[2], 32'h1234_5678);
`endif
    drv(0, 0, 0, 3'b000, 32'h0, 0); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
